// File: rtl/enigma_pkg.sv
// Shared constants and FSM encoding for the Enigma rotor stepping engine.
package enigma_pkg;

  localparam int ALPHABET_SIZE = 26;
  localparam int POS_W         = 5;
  localparam int OUT_W         = 7;
  localparam logic [POS_W-1:0] POS_MAX = 5'd25;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_STEP = 1'b1
  } step_state_e;

  // Out-of-range rotor positions collapse to the first letter.
  function automatic logic [POS_W-1:0] sanitize_pos(input logic [POS_W-1:0] val);
    if (val > POS_MAX) begin
      sanitize_pos = 5'd0;
    end else begin
      sanitize_pos = val;
    end
  endfunction

  function automatic logic [POS_W-1:0] inc_mod26(input logic [POS_W-1:0] val);
    if (val >= POS_MAX) begin
      inc_mod26 = 5'd0;
    end else begin
      inc_mod26 = val + 5'd1;
    end
  endfunction

endpackage

// File: rtl/rotor_pos_counter.sv
// Single rotor position register: mod-26 counter with priority load.
module rotor_pos_counter
  import enigma_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [POS_W-1:0] load_val,
  input  logic             inc,
  output logic [POS_W-1:0] pos
);

  logic [POS_W-1:0] r_pos;

  // Load overrides any increment request issued in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pos <= 5'd0;
    end else if (load) begin
      r_pos <= sanitize_pos(load_val);
    end else if (inc) begin
      r_pos <= inc_mod26(r_pos);
    end else begin
      r_pos <= r_pos;
    end
  end

  assign pos = r_pos;

endmodule

// File: rtl/enigma_step_controller.sv
// Keypress-driven stepping for the three-rotor stack, with notch and
// double-step carries; positions settle two cycles after a detected press.
module enigma_step_controller
  import enigma_pkg::*;
#(
  parameter int RIGHT_NOTCH  = 21,
  parameter int MIDDLE_NOTCH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             key_press,
  input  logic             load_init_state,
  input  logic [POS_W-1:0] init_left,
  input  logic [POS_W-1:0] init_middle,
  input  logic [POS_W-1:0] init_right,
  output logic [OUT_W-1:0] pos_left,
  output logic [OUT_W-1:0] pos_middle,
  output logic [OUT_W-1:0] pos_right,
  output logic             step_done,
  output logic             busy
);

  localparam logic [POS_W-1:0] RN = POS_W'(RIGHT_NOTCH);
  localparam logic [POS_W-1:0] MN = POS_W'(MIDDLE_NOTCH);

  step_state_e      r_state;
  step_state_e      w_next_state;
  logic             r_key_q;
  logic             r_step_done;
  logic             r_busy;
  logic             w_press;
  logic             w_step_en;
  logic             w_inc_left;
  logic             w_inc_middle;
  logic             w_inc_right;
  logic [POS_W-1:0] w_pos_left;
  logic [POS_W-1:0] w_pos_middle;
  logic [POS_W-1:0] w_pos_right;

  // Key history keeps tracking during loads so a held key cannot re-trigger.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_key_q <= 1'b0;
    end else begin
      r_key_q <= key_press;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_step_done <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_step_done <= w_step_en;
      r_busy      <= (w_next_state == ST_STEP);
    end
  end

  always_comb begin
    w_next_state = ST_IDLE;
    w_press      = key_press & ~r_key_q & (r_state == ST_IDLE);
    w_step_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (load_init_state) begin
          w_next_state = ST_IDLE;
        end else if (w_press) begin
          w_next_state = ST_STEP;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_STEP: begin
        w_next_state = ST_IDLE;
        w_step_en    = ~load_init_state;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Middle notch steps the middle rotor itself as well as the left one.
  assign w_inc_right  = w_step_en;
  assign w_inc_middle = w_step_en & ((w_pos_right == RN) | (w_pos_middle == MN));
  assign w_inc_left   = w_step_en & (w_pos_middle == MN);

  rotor_pos_counter u_left (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load_init_state),
    .load_val (init_left),
    .inc      (w_inc_left),
    .pos      (w_pos_left)
  );

  rotor_pos_counter u_middle (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load_init_state),
    .load_val (init_middle),
    .inc      (w_inc_middle),
    .pos      (w_pos_middle)
  );

  rotor_pos_counter u_right (
    .clk      (clk),
    .resetn   (resetn),
    .load     (load_init_state),
    .load_val (init_right),
    .inc      (w_inc_right),
    .pos      (w_pos_right)
  );

  assign pos_left   = {{(OUT_W-POS_W){1'b0}}, w_pos_left};
  assign pos_middle = {{(OUT_W-POS_W){1'b0}}, w_pos_middle};
  assign pos_right  = {{(OUT_W-POS_W){1'b0}}, w_pos_right};
  assign step_done  = r_step_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_enigma_step_controller.sv
// Randomised and directed bench for enigma_step_controller against a
// schedule-based model of keypress stepping.
module tb_enigma_step_controller;

  logic       clk;
  logic       resetn;
  logic       key_press;
  logic       load_init_state;
  logic [4:0] init_left, init_middle, init_right;
  logic [6:0] pos_left, pos_middle, pos_right;
  logic       step_done, busy;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;

  enigma_step_controller #(.RIGHT_NOTCH(21), .MIDDLE_NOTCH(4)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .key_press       (key_press),
    .load_init_state (load_init_state),
    .init_left       (init_left),
    .init_middle     (init_middle),
    .init_right      (init_right),
    .pos_left        (pos_left),
    .pos_middle      (pos_middle),
    .pos_right       (pos_right),
    .step_done       (step_done),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: positions as integers, plus "a step is scheduled at the next edge".
  int mL, mM, mR;
  bit m_sched, m_done, m_prev_key;

  function automatic int san(input int v);
    return (v > 25) ? 0 : v;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mL <= 0; mM <= 0; mR <= 0;
      m_sched <= 1'b0; m_done <= 1'b0; m_prev_key <= 1'b0;
    end else begin
      m_done     <= 1'b0;
      m_sched    <= 1'b0;
      m_prev_key <= key_press;
      if (load_init_state) begin
        mL <= san(int'(init_left));
        mM <= san(int'(init_middle));
        mR <= san(int'(init_right));
      end else if (m_sched) begin
        mR <= (mR + 1) % 26;
        if (mR == 21 || mM == 4) mM <= (mM + 1) % 26;
        if (mM == 4) mL <= (mL + 1) % 26;
        m_done <= 1'b1;
      end else if (key_press && !m_prev_key) begin
        m_sched <= 1'b1;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (resetn) begin
      chk("pos_left",   int'(pos_left),   mL);
      chk("pos_middle", int'(pos_middle), mM);
      chk("pos_right",  int'(pos_right),  mR);
      chk("step_done",  int'(step_done),  int'(m_done));
      chk("busy",       int'(busy),       int'(m_sched));
      if (step_done) n_done++;
    end
  end

  task automatic load_pos(input int l, input int m, input int r);
    @(posedge clk); #2;
    load_init_state = 1'b1;
    init_left = 5'(l); init_middle = 5'(m); init_right = 5'(r);
    @(posedge clk); #2;
    load_init_state = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic press_once();
    @(posedge clk); #2 key_press = 1'b1;
    @(posedge clk); #2 key_press = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic chk_pos(input string name, input int l, input int m, input int r);
    @(negedge clk);
    chk({name, "_L"}, int'(pos_left),   l);
    chk({name, "_M"}, int'(pos_middle), m);
    chk({name, "_R"}, int'(pos_right),  r);
  endtask

  int d0;

  initial begin
    resetn = 1'b0; key_press = 1'b0; load_init_state = 1'b0;
    init_left = 5'd0; init_middle = 5'd0; init_right = 5'd0;
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    chk_pos("reset", 0, 0, 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(step_done), 0);

    // Asynchronous reset in the middle of a step.
    load_pos(3, 4, 5);
    @(posedge clk); #2 key_press = 1'b1;
    @(posedge clk); #2 key_press = 1'b0;
    chk("midstep_busy", int'(busy), 1);
    resetn = 1'b0;
    #1;
    chk("arst_L", int'(pos_left), 0);
    chk("arst_M", int'(pos_middle), 0);
    chk("arst_R", int'(pos_right), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(step_done), 0);
    #3 resetn = 1'b1;

    // Latency: press in cycle N, result and step_done in N+2.
    @(posedge clk); #2 key_press = 1'b1;
    @(negedge clk);
    chk("lat_N_busy", int'(busy), 0);
    @(posedge clk); #2 key_press = 1'b0;
    @(negedge clk);
    chk("lat_N1_busy", int'(busy), 1);
    chk("lat_N1_done", int'(step_done), 0);
    chk("lat_N1_R", int'(pos_right), 0);
    @(negedge clk);
    chk("lat_N2_done", int'(step_done), 1);
    chk("lat_N2_R", int'(pos_right), 1);
    chk("lat_N2_M", int'(pos_middle), 0);
    chk("lat_N2_L", int'(pos_left), 0);
    @(negedge clk);
    chk("lat_N3_done", int'(step_done), 0);

    // Double step.
    load_pos(0, 3, 20);
    d0 = n_done;
    press_once(); chk_pos("dbl1", 0, 3, 21);
    press_once(); chk_pos("dbl2", 0, 4, 22);
    press_once(); chk_pos("dbl3", 1, 5, 23);
    chk("dbl_count", n_done - d0, 3);

    // Wrap with no notch carry.
    load_pos(25, 25, 25);
    press_once(); chk_pos("wrap", 25, 25, 0);

    // Out-of-range load.
    load_pos(30, 26, 25);
    chk_pos("oor", 0, 0, 25);

    // Press and load in the same cycle: load wins.
    d0 = n_done;
    @(posedge clk); #2;
    key_press = 1'b1; load_init_state = 1'b1;
    init_left = 5'd7; init_middle = 5'd8; init_right = 5'd9;
    @(posedge clk); #2 load_init_state = 1'b0; key_press = 1'b0;
    repeat (3) @(posedge clk);
    chk_pos("coll", 7, 8, 9);
    chk("coll_count", n_done - d0, 0);

    // Key bounce inside the STEP cycle yields one step only.
    d0 = n_done;
    @(posedge clk); #2 key_press = 1'b1;
    @(posedge clk); #1 key_press = 1'b0;
    #2 key_press = 1'b1;
    repeat (4) @(posedge clk);
    #2 key_press = 1'b0;
    repeat (3) @(posedge clk);
    chk("busy_edge_count", n_done - d0, 1);
    chk_pos("busy_edge", 7, 8, 10);

    // Held key: one step, then a fresh press gives a second.
    d0 = n_done;
    @(posedge clk); #2 key_press = 1'b1;
    repeat (50) @(posedge clk);
    #2 key_press = 1'b0;
    repeat (3) @(posedge clk);
    chk("held_count", n_done - d0, 1);
    press_once();
    chk("held_repress_count", n_done - d0, 2);
    chk_pos("held", 7, 8, 12);

    // Random traffic, loads biased toward notch neighbourhoods.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      if ($urandom_range(0, 2) == 0) key_press = ~key_press;
      load_init_state = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) == 0) begin
        init_left   = 5'($urandom_range(0, 31));
        init_middle = 5'($urandom_range(0, 31));
        init_right  = 5'($urandom_range(0, 31));
      end else begin
        init_left   = 5'($urandom_range(23, 27));
        init_middle = 5'($urandom_range(2, 5));
        init_right  = 5'($urandom_range(18, 22));
      end
    end
    @(posedge clk); #2 key_press = 1'b0; load_init_state = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
